cell_pos_reader: RTL and testbench
==================================

CELL_POS_READER -- requirements
Module: cell_pos_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, meaning the position word {posz, posy, posx} at 32 bits each.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the cell-memory address width.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, meaning the number of clock cycles from mem_rden to valid mem_q.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output buffer entries; it SHALL be at least RD_LATENCY+2.
REQ-005 The block SHALL have these ports, one clock and an asynchronous active-low reset:
- clock  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start pulse, sampled only in IDLE
- particle_num  in  ADDR_WIDTH+1  number of entries to read
- mem_address  out  ADDR_WIDTH  cell-memory address
- mem_rden  out  1  cell-memory read enable
- mem_wren  out  1  cell-memory write enable, constant 0
- mem_q  in  DATA_WIDTH  cell-memory read data
- out_data  out  DATA_WIDTH  position word
- out_pid  out  ADDR_WIDTH  particle index of out_data
- out_valid  out  1  output stream valid
- out_ready  in  1  output stream ready
- out_last  out  1  marks the final entry
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse on completion
- stall_cnt  out  16  out_valid && !out_ready cycle count

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, READ, DRAIN and DONE.
REQ-007 IDLE SHALL go to READ on start when particle_num>0, latching N=particle_num and setting the issue address to 0.
REQ-008 IDLE SHALL go directly to DONE on start when particle_num==0, and no read or output SHALL occur.
REQ-009 In READ, mem_rden SHALL be asserted with mem_address=issue address only when credit>0, where credit = FIFO_DEPTH - fifo_count - inflight.
REQ-010 After each issued read, the issue address SHALL increment; when the last address N-1 is issued, the FSM SHALL go to DRAIN.
REQ-011 An inflight shift register of length RD_LATENCY SHALL track issued reads; mem_q SHALL be pushed into the FIFO, tagged with its pid, exactly RD_LATENCY cycles after its mem_rden.
REQ-012 The FIFO SHALL never overflow; a push to a full FIFO is a design error and the bench SHALL flag it.
REQ-013 The output SHALL follow valid/ready rules: out_valid = FIFO not empty; out_data and out_pid are the FIFO head; a transfer occurs when out_valid && out_ready.
REQ-014 Once out_valid is asserted, out_data, out_pid and out_last SHALL hold until the transfer.
REQ-015 out_last SHALL be high when out_pid==N-1.
REQ-016 A push and a pop in the same cycle SHALL be allowed, including when the FIFO is full (pop frees the slot first) or empty (no bypass; data appears the next cycle).
REQ-017 DRAIN SHALL go to DONE on the transfer with out_last.
REQ-018 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 With out_ready held high and RD_LATENCY=1, the block SHALL sustain one transfer per cycle; the first out_valid SHALL occur 2 cycles after start (1 cycle issue plus 1 cycle memory latency).
REQ-021 Addresses SHALL be issued in strictly ascending order 0..N-1, and the output order SHALL match the issue order.

Reset
REQ-022 On rst_n low, the block SHALL asynchronously enter IDLE.
REQ-023 On rst_n low, the block SHALL clear the FIFO, inflight register, issue address and stall_cnt.
REQ-024 On rst_n low, the following outputs SHALL reset to 0: mem_rden, mem_address, out_valid, out_last, out_pid, out_data, busy and done.
REQ-025 Reset asserted mid-operation SHALL discard all buffered and inflight data, and memory data arriving after reset release SHALL be ignored.

Configuration
REQ-026 With macro CELL_READER_STALL_CNT_EN defined, stall_cnt SHALL increment once per cycle with out_valid && !out_ready.
REQ-027 Under CELL_READER_STALL_CNT_EN, stall_cnt SHALL clear on an accepted start and SHALL saturate at 16'hFFFF.
REQ-028 Without CELL_READER_STALL_CNT_EN, stall_cnt SHALL be constant 0, with no counter logic synthesized.

Verification
REQ-029 The bench SHALL cover: N=220 with out_ready=1 -> 220 transfers, pids 0..219 in order, out_data equal to the memory image, out_last only at pid 219, first out_valid at start+2, done 222 cycles after start.
REQ-030 The bench SHALL cover: N=5 with out_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH=4 reads issued while stalled, no overflow, all 5 delivered in order, stall_cnt=20 (macro on) or 0 (macro off).
REQ-031 The bench SHALL cover: random out_ready (50%), N=64 -> no data loss or duplication, out_data stable while stalled, credit never below 0.
REQ-032 The bench SHALL cover: start with particle_num=0 -> done pulse 1 cycle later, mem_rden never asserted, out_valid never asserted.
REQ-033 The bench SHALL cover: rst_n low at pid 10 of N=100 -> all outputs 0 immediately; after release and a new start with N=3, only pids 0..2 are delivered.
REQ-034 The bench SHALL cover: a second start while busy -> ignored; current run completes unchanged.

Source files
------------

// File: rtl/cell_pos_reader.sv
// Streams N position words from cell memory into a small credit-controlled output FIFO.
// Optional stall counter is built only when CELL_READER_STALL_CNT_EN is defined.
module cell_pos_reader #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   particle_num,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   n_reg, n_next;
  logic [ADDR_WIDTH:0]   issue_reg, issue_next;

  logic                  infl_vld_reg [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] infl_pid_reg [RD_LATENCY];
  logic [CNT_W-1:0]      inflight_cnt;

  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pid_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;

  logic                  credit_ok, issue, push, pop;
  logic [ADDR_WIDTH-1:0] head_pid;

  // Credit counts both queued and in-flight words so a push can never find the FIFO full.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(infl_vld_reg[i]);
    end
  end

  assign credit_ok = (fifo_count_reg + inflight_cnt) < CNT_W'(FIFO_DEPTH);
  assign issue     = (state_reg == READ) && credit_ok;
  assign push      = infl_vld_reg[RD_LATENCY-1];
  assign out_valid = (fifo_count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign head_pid  = fifo_pid_mem[rd_ptr_reg];

  assign out_data    = out_valid ? fifo_data_mem[rd_ptr_reg] : '0;
  assign out_pid     = out_valid ? head_pid : '0;
  assign out_last    = out_valid && ({1'b0, head_pid} == (n_reg - 1'b1));
  assign mem_rden    = issue;
  assign mem_address = issue ? issue_reg[ADDR_WIDTH-1:0] : '0;
  assign mem_wren    = 1'b0;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    issue_next = issue_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          n_next     = particle_num;
          issue_next = '0;
          state_next = (particle_num == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          issue_next = issue_reg + 1'b1;
          if (issue_reg == (n_reg - 1'b1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      issue_reg <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      issue_reg <= issue_next;
    end
  end

  // Stage RD_LATENCY-1 lines up with mem_q for the read issued RD_LATENCY cycles earlier.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        infl_vld_reg[i] <= 1'b0;
        infl_pid_reg[i] <= '0;
      end
    end else begin
      infl_vld_reg[0] <= issue;
      infl_pid_reg[0] <= issue_reg[ADDR_WIDTH-1:0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        infl_vld_reg[i] <= infl_vld_reg[i-1];
        infl_pid_reg[i] <= infl_pid_reg[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= mem_q;
      fifo_pid_mem[wr_ptr_reg]  <= infl_pid_reg[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

`ifdef CELL_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader: memory model, transfer monitor and one task per scenario.
module tb_cell_pos_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int RL = 1;
  localparam int FD = 4;
`ifdef CELL_READER_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   particle_num = '0;
  logic [AW-1:0] mem_address;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_pid;
  logic          out_valid, out_last, busy, done;
  logic          out_ready = 1'b0;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] mem_img [256];
  int cyc = 0;
  int total_cnt = 0;
  int pass_cnt = 0;

  cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .clock(clk), .rst_n(rst_n), .start(start), .particle_num(particle_num),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .out_data(out_data), .out_pid(out_pid), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rden) mem_q <= mem_img[mem_address];

  // Monitor: values seen at the falling edge are what the next rising edge acts on.
  logic [AW-1:0] x_pid_q [$];
  logic [DW-1:0] x_data_q [$];
  logic          x_last_q [$];
  int rden_total = 0, stab_viol = 0, stall_seen = 0, outstanding = 0, max_out = 0;
  logic          p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic [AW-1:0] p_pid = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
      outstanding = 0;
    end else begin
      if (p_valid && !p_ready &&
          (!out_valid || out_data !== p_data || out_pid !== p_pid || out_last !== p_last))
        stab_viol++;
      if (out_valid && out_ready) begin
        x_pid_q.push_back(out_pid);
        x_data_q.push_back(out_data);
        x_last_q.push_back(out_last);
        outstanding--;
      end
      if (out_valid && !out_ready) stall_seen++;
      if (mem_rden) begin
        rden_total++;
        outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_pid = out_pid; p_last = out_last;
    end
  end

  task automatic do_start(input int n, output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    particle_num = (AW+1)'(n);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2; rst_n = 1'b0; #10;
    total_cnt++; if (mem_rden !== 1'b0) $display("FAIL reset_mem_rden: got %0b expected 0", mem_rden); else pass_cnt++;
    total_cnt++; if (mem_address !== '0) $display("FAIL reset_mem_address: got %0h expected 0", mem_address); else pass_cnt++;
    total_cnt++; if (mem_wren !== 1'b0) $display("FAIL reset_mem_wren: got %0b expected 0", mem_wren); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b expected 0", out_last); else pass_cnt++;
    total_cnt++; if (out_pid !== '0) $display("FAIL reset_out_pid: got %0h expected 0", out_pid); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %0h expected 0", out_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_after_release: busy got %0b expected 0", busy); else pass_cnt++;
    $display("reset: outputs cleared during reset, idle after release");
  endtask

  task automatic test_full_rate();
    int t0, first_v, dcyc, base, bad_pid, bad_data, bad_last;
    first_v = -1; dcyc = -1; bad_pid = 0; bad_data = 0; bad_last = 0;
    base = x_pid_q.size();
    out_ready = 1'b1;
    do_start(220, t0);
    for (int i = 0; i < 400 && dcyc < 0; i++) begin
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) dcyc = cyc;
    end
    for (int i = 0; i < 220 && base + i < x_pid_q.size(); i++) begin
      if (x_pid_q[base+i] !== AW'(i)) bad_pid++;
      if (x_data_q[base+i] !== mem_img[i]) bad_data++;
      if (x_last_q[base+i] !== (i == 219)) bad_last++;
    end
    total_cnt++; if (first_v !== t0 + 2) $display("FAIL full_first_valid: got cycle %0d expected %0d", first_v, t0 + 2); else pass_cnt++;
    total_cnt++; if (dcyc !== t0 + 222) $display("FAIL full_done_cycle: got %0d expected %0d", dcyc, t0 + 222); else pass_cnt++;
    total_cnt++; if (x_pid_q.size() - base !== 220) $display("FAIL full_count: got %0d expected 220", x_pid_q.size() - base); else pass_cnt++;
    total_cnt++; if (bad_pid !== 0) $display("FAIL full_pid_order: got %0d bad expected 0", bad_pid); else pass_cnt++;
    total_cnt++; if (bad_data !== 0) $display("FAIL full_data: got %0d bad expected 0", bad_data); else pass_cnt++;
    total_cnt++; if (bad_last !== 0) $display("FAIL full_last: got %0d bad expected 0", bad_last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL full_done_width: got %0b expected 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL full_idle: busy got %0b expected 0", busy); else pass_cnt++;
    $display("run N=220 ready=1: first_valid=+%0d done=+%0d transfers=%0d", first_v - t0, dcyc - t0, x_pid_q.size() - base);
  endtask

  task automatic test_stall();
    int t0, dcyc, base, r0, got, bad_pid, bad_data, bad_last, exp_stall;
    dcyc = -1; got = 0; bad_pid = 0; bad_data = 0; bad_last = 0;
    exp_stall = STALL_EN ? 20 : 0;
    base = x_pid_q.size(); r0 = rden_total;
    out_ready = 1'b0;
    do_start(5, t0);
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    total_cnt++; if (got !== 1) $display("FAIL stall_valid_seen: got %0d expected 1", got); else pass_cnt++;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++; if (rden_total - r0 !== FD) $display("FAIL stall_reads_issued: got %0d expected %0d", rden_total - r0, FD); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL stall_cnt_value: got %0d expected %0d", stall_cnt, exp_stall); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && dcyc < 0; i++) begin
      @(negedge clk);
      if (done) dcyc = cyc;
    end
    for (int i = 0; i < 5 && base + i < x_pid_q.size(); i++) begin
      if (x_pid_q[base+i] !== AW'(i)) bad_pid++;
      if (x_data_q[base+i] !== mem_img[i]) bad_data++;
      if (x_last_q[base+i] !== (i == 4)) bad_last++;
    end
    total_cnt++; if (dcyc < 0) $display("FAIL stall_done_timeout: got %0d expected done", dcyc); else pass_cnt++;
    total_cnt++; if (x_pid_q.size() - base !== 5) $display("FAIL stall_count: got %0d expected 5", x_pid_q.size() - base); else pass_cnt++;
    total_cnt++; if (bad_pid + bad_data + bad_last !== 0) $display("FAIL stall_order_data: got %0d bad expected 0", bad_pid + bad_data + bad_last); else pass_cnt++;
    total_cnt++; if (rden_total - r0 !== 5) $display("FAIL stall_total_reads: got %0d expected 5", rden_total - r0); else pass_cnt++;
    total_cnt++; if (max_out > FD) $display("FAIL stall_overflow: got %0d outstanding expected <= %0d", max_out, FD); else pass_cnt++;
    $display("run N=5 stalled 20: reads_while_stalled=%0d stall_cnt=%0d transfers=%0d", FD, stall_cnt, x_pid_q.size() - base);
  endtask

  task automatic test_random();
    int t0, dcyc, base, s0, v0, bad_pid, bad_data, bad_last, exp_stall;
    dcyc = -1; bad_pid = 0; bad_data = 0; bad_last = 0;
    base = x_pid_q.size(); s0 = stall_seen; v0 = stab_viol;
    out_ready = 1'b0;
    do_start(64, t0);
    for (int i = 0; i < 2000 && dcyc < 0; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) dcyc = cyc;
    end
    out_ready = 1'b1;
    exp_stall = STALL_EN ? (stall_seen - s0) : 0;
    for (int i = 0; i < 64 && base + i < x_pid_q.size(); i++) begin
      if (x_pid_q[base+i] !== AW'(i)) bad_pid++;
      if (x_data_q[base+i] !== mem_img[i]) bad_data++;
      if (x_last_q[base+i] !== (i == 63)) bad_last++;
    end
    total_cnt++; if (dcyc < 0) $display("FAIL rand_done_timeout: got %0d expected done", dcyc); else pass_cnt++;
    total_cnt++; if (x_pid_q.size() - base !== 64) $display("FAIL rand_count: got %0d expected 64", x_pid_q.size() - base); else pass_cnt++;
    total_cnt++; if (bad_pid !== 0) $display("FAIL rand_pid_order: got %0d bad expected 0", bad_pid); else pass_cnt++;
    total_cnt++; if (bad_data !== 0) $display("FAIL rand_data: got %0d bad expected 0", bad_data); else pass_cnt++;
    total_cnt++; if (bad_last !== 0) $display("FAIL rand_last: got %0d bad expected 0", bad_last); else pass_cnt++;
    total_cnt++; if (stab_viol - v0 !== 0) $display("FAIL rand_hold_stable: got %0d changes expected 0", stab_viol - v0); else pass_cnt++;
    total_cnt++; if (max_out > FD) $display("FAIL rand_credit: got %0d outstanding expected <= %0d", max_out, FD); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); else pass_cnt++;
    $display("run N=64 random ready: transfers=%0d stalls=%0d done=+%0d", x_pid_q.size() - base, stall_seen - s0, dcyc - t0);
  endtask

  task automatic test_zero();
    int t0, r0, first_done, done_n, valid_n;
    first_done = -1; done_n = 0; valid_n = 0;
    r0 = rden_total;
    out_ready = 1'b1;
    do_start(0, t0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (first_done < 0) first_done = cyc;
      end
      if (out_valid) valid_n++;
    end
    total_cnt++; if (first_done !== t0) $display("FAIL zero_done_cycle: got %0d expected %0d", first_done, t0); else pass_cnt++;
    total_cnt++; if (done_n !== 1) $display("FAIL zero_done_pulses: got %0d expected 1", done_n); else pass_cnt++;
    total_cnt++; if (rden_total - r0 !== 0) $display("FAIL zero_no_read: got %0d expected 0", rden_total - r0); else pass_cnt++;
    total_cnt++; if (valid_n !== 0) $display("FAIL zero_no_valid: got %0d expected 0", valid_n); else pass_cnt++;
    $display("run N=0: done_pulses=%0d reads=%0d", done_n, rden_total - r0);
  endtask

  task automatic test_reset_mid();
    int t0, dcyc, base, r0, found, bad;
    dcyc = -1; found = 0; bad = 0;
    out_ready = 1'b1;
    do_start(100, t0);
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (out_valid && out_pid == AW'(10)) found = 1;
    end
    total_cnt++; if (found !== 1) $display("FAIL mid_reach_pid10: got %0d expected 1", found); else pass_cnt++;
    #2; rst_n = 1'b0; #1;
    total_cnt++; if (mem_rden !== 1'b0) $display("FAIL mid_mem_rden: got %0b expected 0", mem_rden); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_pid !== '0) $display("FAIL mid_out_pid: got %0h expected 0", out_pid); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL mid_out_data: got %0h expected 0", out_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_busy_done: got %0b%0b expected 00", busy, done); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = x_pid_q.size(); r0 = rden_total;
    do_start(3, t0);
    for (int i = 0; i < 50 && dcyc < 0; i++) begin
      @(negedge clk);
      if (done) dcyc = cyc;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3 && base + i < x_pid_q.size(); i++) begin
      if (x_pid_q[base+i] !== AW'(i) || x_data_q[base+i] !== mem_img[i] || x_last_q[base+i] !== (i == 2)) bad++;
    end
    total_cnt++; if (x_pid_q.size() - base !== 3) $display("FAIL mid_restart_count: got %0d expected 3", x_pid_q.size() - base); else pass_cnt++;
    total_cnt++; if (bad !== 0) $display("FAIL mid_restart_data: got %0d bad expected 0", bad); else pass_cnt++;
    total_cnt++; if (rden_total - r0 !== 3) $display("FAIL mid_restart_reads: got %0d expected 3", rden_total - r0); else pass_cnt++;
    $display("run N=100 reset at pid 10, restart N=3: transfers=%0d", x_pid_q.size() - base);
  endtask

  task automatic test_back_to_back();
    int t0, base, r0, done_n, bad;
    done_n = 0; bad = 0;
    base = x_pid_q.size(); r0 = rden_total;
    out_ready = 1'b1;
    do_start(8, t0);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; particle_num = (AW+1)'(3);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    for (int i = 0; i < 8 && base + i < x_pid_q.size(); i++) begin
      if (x_pid_q[base+i] !== AW'(i) || x_data_q[base+i] !== mem_img[i] || x_last_q[base+i] !== (i == 7)) bad++;
    end
    total_cnt++; if (x_pid_q.size() - base !== 8) $display("FAIL b2b_count: got %0d expected 8", x_pid_q.size() - base); else pass_cnt++;
    total_cnt++; if (bad !== 0) $display("FAIL b2b_order_data: got %0d bad expected 0", bad); else pass_cnt++;
    total_cnt++; if (done_n !== 1) $display("FAIL b2b_done_pulses: got %0d expected 1", done_n); else pass_cnt++;
    total_cnt++; if (rden_total - r0 !== 8) $display("FAIL b2b_reads: got %0d expected 8", rden_total - r0); else pass_cnt++;
    $display("run N=8 with second start while busy: transfers=%0d done_pulses=%0d", x_pid_q.size() - base, done_n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_img[i] = {32'(i * 7 + 3), 32'((i * 13) ^ 32'h5A5A_0000), 32'(32'hC000_0000 + i)};
    end
    test_reset();
    test_full_rate();
    test_stall();
    test_random();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
